// File: rtl/nibble_packer.sv
// rtl/nibble_packer.sv - packs 4-bit nibbles into NIB_NUM-nibble words with flush support
module nibble_packer #(
    parameter  int NIB_NUM = 4,
    localparam int OUT_W   = 4 * NIB_NUM
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [3:0]       out_cnt,
    output logic             out_partial
);

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        FLUSH_PEND
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(NIB_NUM - 1);
    localparam logic [3:0] FULL_CNT = 4'(NIB_NUM);

    state_t           state;
    logic [OUT_W-1:0] acc;
    logic [3:0]       acc_cnt;

    logic             out_free;
    logic             accept;
    logic [5:0]       shamt;
    logic [OUT_W-1:0] nib_shift;
    logic [OUT_W-1:0] acc_next;
    logic [3:0]       cnt_next;
    logic             full;
    logic             flush_req;
    logic             load_part;
    logic             park;

    // Handshake decode and next-accumulator computation for this cycle
    always_comb begin
        out_free  = !out_valid || out_ready;
        // The last slot is only offered when the completed word can move out.
        in_ready  = !rst && (state != FLUSH_PEND) && ((acc_cnt < LAST_CNT) || out_free);
        accept    = in_valid && in_ready;
        shamt     = {acc_cnt, 2'b00};
        nib_shift = {{(OUT_W-4){1'b0}}, in_data} << shamt;
        acc_next  = accept ? (acc | nib_shift) : acc;
        cnt_next  = acc_cnt + {3'b000, accept};
        full      = accept && (cnt_next == FULL_CNT);
        // A flush that coincides with the completing nibble is absorbed by the full word.
        flush_req = (flush || (state == FLUSH_PEND)) && (cnt_next != 4'd0) && !full;
        load_part = flush_req && out_free;
        park      = flush_req && !out_free;
    end

    // Control FSM with accumulator and registered output word
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            acc         <= '0;
            acc_cnt     <= 4'd0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_cnt     <= 4'd0;
            out_partial <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (full || load_part) begin
                out_valid   <= 1'b1;
                out_data    <= acc_next;
                out_cnt     <= cnt_next;
                out_partial <= load_part;
                acc         <= '0;
                acc_cnt     <= 4'd0;
                state       <= EMPTY;
            end else begin
                acc     <= acc_next;
                acc_cnt <= cnt_next;
                if (park) begin
                    state <= FLUSH_PEND;
                end else if (cnt_next != 4'd0) begin
                    state <= FILL;
                end else begin
                    state <= EMPTY;
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_packer.sv
// tb/tb_nibble_packer.sv - self-checking bench for nibble_packer
module tb_nibble_packer;

    localparam int N = 4;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  c;
        logic        p;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_cnt;
    logic        out_partial;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int vcount   = 0;

    logic [3:0] acc_q[$];
    word_t      exp_q[$];
    word_t      got[$];
    int         tcyc[$];

    nibble_packer #(.NIB_NUM(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_cnt     (out_cnt),
        .out_partial (out_partial)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic word_t make_word(input logic partial);
        word_t w;
        w.d = 16'h0;
        for (int i = 0; i < acc_q.size(); i++) begin
            w.d[4*i +: 4] = acc_q[i];
        end
        w.c = 4'(acc_q.size());
        w.p = partial;
        return w;
    endfunction

    // Reference model: word order from the accepted nibble stream and flushes
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("in_ready_in_reset", in_ready, 0);
            acc_q.delete();
            exp_q.delete();
        end else begin
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("in_ready", in_ready,
                (exp_q.size() <= 1) && ((acc_q.size() < N-1) || (exp_q.size() == 0) || out_ready));
            if (out_valid && exp_q.size() > 0) begin
                chk("out_data", out_data, exp_q[0].d);
                chk("out_cnt", out_cnt, exp_q[0].c);
                chk("out_partial", out_partial, exp_q[0].p);
            end
            if (out_valid) vcount++;
            if (out_valid && out_ready) begin
                word_t w;
                w.d = out_data;
                w.c = out_cnt;
                w.p = out_partial;
                got.push_back(w);
                tcyc.push_back(cyc);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                acc_q.push_back(in_data);
                if (acc_q.size() == N) begin
                    exp_q.push_back(make_word(1'b0));
                    acc_q.delete();
                end else if (flush) begin
                    exp_q.push_back(make_word(1'b1));
                    acc_q.delete();
                end
            end else if (flush && acc_q.size() > 0) begin
                exp_q.push_back(make_word(1'b1));
                acc_q.delete();
            end
        end
    end

    task automatic send(input logic [3:0] d, input logic f);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        flush    = f;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string name, input int idx, input logic [15:0] d,
                            input logic [3:0] c, input logic p);
        chk({name, "_present"}, got.size() > idx, 1);
        if (got.size() > idx) begin
            chk({name, "_data"}, got[idx].d, d);
            chk({name, "_cnt"}, got[idx].c, c);
            chk({name, "_partial"}, got[idx].p, p);
        end
    endtask

    initial begin
        int base;
        int v0;
        int n0;
        bit ok;
        rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_cnt", out_cnt, 0);
        chk("reset_out_partial", out_partial, 0);
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // streaming
        base = got.size(); v0 = vcount;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send(4'(i), 1'b0);
        idle(4);
        chk_word("stream", base, 16'h4321, 4'd4, 1'b0);
        chk("stream_valid_cycles", vcount - v0, 1);

        // backpressure
        base = got.size();
        out_ready = 1'b0;
        for (int i = 1; i <= 7; i++) send(4'(i), 1'b0);
        in_valid = 1'b1; in_data = 4'h8;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_held_data", out_data, 16'h4321);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        ok = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        chk("bp_accept", ok, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        idle(4);
        chk_word("bp_first", base, 16'h4321, 4'd4, 1'b0);
        chk_word("bp_second", base + 1, 16'h8765, 4'd4, 1'b0);

        // flush
        base = got.size();
        send(4'h5, 1'b0);
        send(4'h6, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 1);
        @(posedge clk); #1 flush = 1'b0;
        idle(3);
        chk_word("flush", base, 16'h0065, 4'd2, 1'b1);

        // pending flush
        base = got.size();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(4'(i), 1'b0);
        send(4'h7, 1'b0);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("pend_in_ready", in_ready, 0);
        @(posedge clk); #1 out_ready = 1'b1;
        idle(4);
        chk_word("pend_first", base, 16'h4321, 4'd4, 1'b0);
        chk_word("pend_second", base + 1, 16'h0007, 4'd1, 1'b1);
        if (got.size() > base + 1) chk("pend_back_to_back", tcyc[base+1] - tcyc[base], 1);

        // simultaneous flush and completing nibble, then flush in EMPTY
        base = got.size();
        send(4'hA, 1'b0);
        send(4'hB, 1'b0);
        send(4'hC, 1'b0);
        send(4'hD, 1'b1);
        idle(4);
        chk_word("simul", base, 16'hDCBA, 4'd4, 1'b0);
        chk("simul_one_word", got.size() - base, 1);
        n0 = got.size();
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        idle(4);
        chk("empty_flush_no_word", got.size() - n0, 0);

        // reset mid-operation
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_cnt", out_cnt, 0);
        chk("midrst_out_partial", out_partial, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        base = got.size();
        for (int i = 3; i <= 6; i++) send(4'(i), 1'b0);
        idle(4);
        chk_word("midrst", base, 16'h6543, 4'd4, 1'b0);
        chk("model_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
